// File: rtl/flow_pkg.sv
// Shared definitions for the fetch stage: default geometry, reset PC and the
// fetch FSM state encoding.
package flow_pkg;

  localparam int ADDR_W_DEFAULT   = 8;
  localparam int RESET_PC_DEFAULT = 0;

  localparam logic [2:0] ST_FETCH = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_PREF  = 3'd2;
  localparam logic [2:0] ST_PFCAP = 3'd3;
  localparam logic [2:0] ST_HOLD  = 3'd4;

  typedef enum logic [2:0] {
    S_FETCH = ST_FETCH,
    S_LOAD  = ST_LOAD,
    S_PREF  = ST_PREF,
    S_PFCAP = ST_PFCAP,
    S_HOLD  = ST_HOLD
  } fetch_state_e;

  // States that put a read on the instruction memory this cycle.
  function automatic logic issues_read(fetch_state_e s);
    return (s == S_FETCH) || (s == S_PREF);
  endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: control-path handshake plus the instruction memory read port.
// master = fetch stage, slave = surrounding datapath (control path + memory).
interface instruction_fetch_if
  import flow_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT
);

  logic              program_counter_increment;
  logic              jump;
  logic [15:0]       jump_target;
  logic [15:0]       mem_rdata;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       current_instruction;
  logic              instruction_valid;
  logic [ADDR_W-1:0] program_counter;

  modport master (
    input  program_counter_increment, jump, jump_target, mem_rdata,
    output mem_rd_en, mem_addr, current_instruction, instruction_valid, program_counter
  );

  modport slave (
    output program_counter_increment, jump, jump_target, mem_rdata,
    input  mem_rd_en, mem_addr, current_instruction, instruction_valid, program_counter
  );

endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the PC, reads a synchronous-read instruction
// memory and keeps one prefetched word so sequential issue can avoid bubbles.
module instruction_fetch
  import flow_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEFAULT,
  parameter int RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                clock,
  input  logic                reset,
  instruction_fetch_if.master bus
);

  localparam logic [ADDR_W-1:0] RESET_PC_A = ADDR_W'(RESET_PC);

  fetch_state_e      state_reg;
  logic [ADDR_W-1:0] pc_reg;
  logic [15:0]       ir_reg;
  logic [15:0]       pf_buf_reg;
  logic              valid_reg;

  logic [ADDR_W-1:0] pc_plus1;
  logic [ADDR_W-1:0] jump_pc;
  logic              take_jump;
  logic              take_inc;

  assign pc_plus1  = pc_reg + ADDR_W'(1);
  assign jump_pc   = bus.jump_target[ADDR_W-1:0];
  assign take_jump = valid_reg & bus.jump;
  assign take_inc  = valid_reg & bus.program_counter_increment & ~bus.jump;

  // S_PREF reads pc+1 speculatively; every other read targets the PC itself.
  assign bus.mem_rd_en = issues_read(state_reg);
  assign bus.mem_addr  = (state_reg == S_PREF) ? pc_plus1 : pc_reg;

  assign bus.current_instruction = ir_reg;
  assign bus.instruction_valid   = valid_reg;
  assign bus.program_counter     = pc_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg  <= S_FETCH;
      pc_reg     <= RESET_PC_A;
      ir_reg     <= 16'h0000;
      pf_buf_reg <= 16'h0000;
      valid_reg  <= 1'b0;
    end else begin
      case (state_reg)
        S_FETCH: begin
          state_reg <= S_LOAD;
        end

        S_LOAD: begin
          ir_reg    <= bus.mem_rdata;
          valid_reg <= 1'b1;
          state_reg <= S_PREF;
        end

        S_PREF: begin
          if (take_jump) begin
            pc_reg    <= jump_pc;
            valid_reg <= 1'b0;
            state_reg <= S_FETCH;
          end else if (take_inc) begin
            // The speculative read already in flight is for the new PC.
            pc_reg    <= pc_plus1;
            valid_reg <= 1'b0;
            state_reg <= S_LOAD;
          end else begin
            state_reg <= S_PFCAP;
          end
        end

        S_PFCAP: begin
          pf_buf_reg <= bus.mem_rdata;
          if (take_jump) begin
            pc_reg    <= jump_pc;
            valid_reg <= 1'b0;
            state_reg <= S_FETCH;
          end else if (take_inc) begin
            ir_reg    <= bus.mem_rdata;
            pc_reg    <= pc_plus1;
            state_reg <= S_PREF;
          end else begin
            state_reg <= S_HOLD;
          end
        end

        S_HOLD: begin
          if (take_jump) begin
            pc_reg    <= jump_pc;
            valid_reg <= 1'b0;
            state_reg <= S_FETCH;
          end else if (take_inc) begin
            ir_reg    <= pf_buf_reg;
            pc_reg    <= pc_plus1;
            state_reg <= S_PREF;
          end
        end

        default: begin
          valid_reg <= 1'b0;
          state_reg <= S_FETCH;
        end
      endcase
    end
  end

endmodule
